mcu0_intc: RTL
==============

Name: mcu0_intc

Overview:
Priority interrupt controller in front of the mcu0 core's single `interrupt` input and 3-bit `irq` vector input. It latches up to 8 request lines, applies masking and fixed priority, and holds the request until the core acknowledges. It tracks in-service sources until end-of-interrupt. A small register port lets a bus master read or configure the mask, pending, in-service and trigger-mode registers.

Parameters:
NSRC, 8, number of request lines; must satisfy NSRC <= 2**VW.
VW, 3, vector width; matches the core's irq[2:0].

Ports:
clock  input  1  system clock, posedge.
reset  input  1  synchronous, active-high reset.
src  input  NSRC  raw request lines; index 0 has the highest priority.
iack  input  1  one-cycle pulse: core has taken the interrupt.
eoi  input  1  one-cycle pulse: core has finished servicing (issued at IRET).
interrupt  output  1  request to the core; registered.
irq  output  VW  vector of the asserted source; registered.
cfg_we  input  1  register write strobe.
cfg_addr  input  2  register select: 0 MASK, 1 PENDING, 2 INSERVICE, 3 TRIG.
cfg_wdata  input  NSRC  write data.
cfg_rdata  output  NSRC  combinational read of the addressed register.

Behaviour:
- Reset values: mask=all 1s (all sources masked), pending=0, isr=0, trig=all 1s (edge mode), src_q=0, state=IDLE, interrupt=0, irq=0.
- Edge source (trig[i]=1):
  - pending[i] is set on the clock where src[i]=1 and src_q[i]=0; src_q is src registered.
  - pending[i] is cleared by iack for that vector, or by a write of 1 to PENDING bit i.
  - If a set and a clear occur in the same cycle, the set wins.
- Level source (trig[i]=0): pending[i] is loaded with src[i] every cycle. iack and PENDING writes have no effect on it.
- Eligibility: elig = pending & ~mask & above(isr). above(isr) selects sources whose index is strictly lower than the lowest set index in isr; it selects all sources when isr=0.
- FSM has two states, IDLE and ASSERT.
  - IDLE: if elig is non-zero, latch vec = lowest set index of elig, move to ASSERT, and drive interrupt=1, irq=vec from the next cycle. Latency from src rising to interrupt=1 is 2 clocks.
  - ASSERT: interrupt and irq are held stable. A higher-priority arrival does not change irq.
  - ASSERT, iack=1: clear pending[vec] (edge mode only), set isr[vec], go to IDLE, and deassert interrupt on the next cycle.
  - ASSERT, iack=0 and elig[vec]=0 (source masked or cleared): retract. Go to IDLE and deassert interrupt on the next cycle.
  - iack while in IDLE is ignored.
- EOI: clears the lowest set index of isr. With isr=0 it is a no-op.
  - If eoi and iack arrive in the same cycle, eoi acts on the pre-update isr, then isr[vec] is set.
- Register writes:
  - MASK and TRIG load cfg_wdata.
  - PENDING is write-1-to-clear.
  - INSERVICE is read-only; writes are ignored.
  - A write takes effect for the eligibility evaluation on the following cycle.
- Reset asserted mid-operation: all state returns to its reset value on that clock. Any outstanding request is dropped without waiting for iack.

Optional Feature:
NESTING_EN
- Defined: above(isr) gating as described, so a higher-priority source can preempt one that is in service.
- Undefined: elig is forced to 0 whenever isr is non-zero. At most one source is in service, and eoi clears all of isr.

Decomposition:
- Package mcu0_intc_pkg holds:
  - the FSM state encoding (IDLE, ASSERT);
  - register address constants (MASK=0, PENDING=1, INSERVICE=2, TRIG=3);
  - reset constants (MASK_RST and TRIG_RST, both all 1s).
- One sub-module, mcu0_intc_prienc: parameterised lowest-set-index priority encoder that outputs a valid flag and an index. It is instantiated twice, once for elig and once for isr.

Test Plan:
- After reset, write MASK=8'hFB and pulse src[2] -> interrupt=1, irq=2 exactly 2 clocks after the edge; hold for 5 cycles without iack -> outputs stable.
- With src[5] and src[1] rising together and MASK=0 -> irq=1. Pulse iack -> isr=8'h02 and pending=8'h20; src[5] is not eligible until eoi, then irq=5.
- NESTING_EN: with isr=8'h08 (source 3 in service), edge on src[1] -> interrupt with irq=1. Without NESTING_EN, no interrupt until eoi.
- Request on src[4] in ASSERT with no iack, then write MASK bit 4=1 -> interrupt drops the next cycle and pending[4] stays 1; unmask -> request reasserts with irq=4.
- Level mode (TRIG=8'h00), src[6] held high: iack sets isr[6] and pending stays 1; drop src[6] then eoi -> no further interrupt. A PENDING write of 8'h40 has no effect.
- Simultaneous new edge on src[2] and iack for vec=2 -> pending[2] stays 1 and isr[2]=1. Assert reset during ASSERT -> interrupt=0 and all registers at reset values on the next cycle.

Source files
------------

// File: rtl/mcu0_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu0_intc_pkg
// Purpose  : Shared constants for the mcu0 priority interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package mcu0_intc_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ASSERT = 1'b1;

    localparam logic [1:0] ADDR_MASK      = 2'd0;
    localparam logic [1:0] ADDR_PENDING   = 2'd1;
    localparam logic [1:0] ADDR_INSERVICE = 2'd2;
    localparam logic [1:0] ADDR_TRIG      = 2'd3;

    // Wide enough for any legal NSRC; the top slices to NSRC bits.
    localparam int                 MAX_SRC  = 32;
    localparam logic [MAX_SRC-1:0] MASK_RST = '1;
    localparam logic [MAX_SRC-1:0] TRIG_RST = '1;

endpackage
`default_nettype wire

// File: rtl/mcu0_intc_prienc.sv
`default_nettype none
// ============================================================================
// Module   : mcu0_intc_prienc
// Purpose  : Lowest-set-index priority encoder with a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module mcu0_intc_prienc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcu0_intc.sv
`default_nettype none
// ============================================================================
// Module   : mcu0_intc
// Purpose  : 8-line fixed-priority interrupt controller for the mcu0 core.
//            Define NESTING_EN to allow higher-priority preemption of a
//            source that is in service.
// Revision : 1.0 - initial release
// ============================================================================
module mcu0_intc
    import mcu0_intc_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int VW   = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            iack,
    input  logic            eoi,
    output logic            interrupt,
    output logic [VW-1:0]   irq,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [NSRC-1:0] cfg_wdata,
    output logic [NSRC-1:0] cfg_rdata
);

    logic [NSRC-1:0] r_src_q, r_mask_q, r_pend_q, r_isr_q, r_trig_q;
    logic [NSRC-1:0] w_mask_d, w_pend_d, w_isr_d, w_trig_d;
    logic [0:0]      r_state_q, w_state_d;
    logic [VW-1:0]   r_vec_q, w_vec_d;
    logic            r_int_q;

    logic [NSRC-1:0] w_edge, w_vec_oh, w_ack_clr, w_w1c, w_above, w_elig, w_eoi_clr;
    logic            w_ack, w_elig_valid, w_isr_valid;
    logic [VW-1:0]   w_elig_idx, w_isr_idx;

    mcu0_intc_prienc #(.N(NSRC), .W(VW)) u_enc_elig (
        .i_req   (w_elig),
        .o_valid (w_elig_valid),
        .o_idx   (w_elig_idx)
    );

    mcu0_intc_prienc #(.N(NSRC), .W(VW)) u_enc_isr (
        .i_req   (r_isr_q),
        .o_valid (w_isr_valid),
        .o_idx   (w_isr_idx)
    );

`ifdef NESTING_EN
    // Only sources strictly above the highest-priority in-service one may fire.
    assign w_above   = w_isr_valid ? ((NSRC'(1) << w_isr_idx) - NSRC'(1)) : '1;
    assign w_eoi_clr = w_isr_valid ? (NSRC'(1) << w_isr_idx) : '0;
`else
    logic w_unused_isr_idx;
    assign w_unused_isr_idx = ^w_isr_idx;
    assign w_above   = w_isr_valid ? '0 : '1;
    assign w_eoi_clr = '1;
`endif

    assign w_elig = r_pend_q & ~r_mask_q & w_above;

    always_comb begin
        w_edge    = src & ~r_src_q;
        w_ack     = (r_state_q == ST_ASSERT) && iack;
        w_vec_oh  = NSRC'(1) << r_vec_q;
        w_ack_clr = w_ack ? w_vec_oh : '0;
        w_w1c     = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : '0;

        w_mask_d = (cfg_we && cfg_addr == ADDR_MASK) ? cfg_wdata : r_mask_q;
        w_trig_d = (cfg_we && cfg_addr == ADDR_TRIG) ? cfg_wdata : r_trig_q;

        // Edge bits: a new edge beats any clear; level bits follow src directly.
        w_pend_d = (r_trig_q & (w_edge | (r_pend_q & ~(w_ack_clr | w_w1c))))
                 | (~r_trig_q & src);

        // EOI acts on the pre-update isr, then the acknowledged vector is set.
        w_isr_d = (r_isr_q & ~(eoi ? w_eoi_clr : '0)) | w_ack_clr;

        w_state_d = r_state_q;
        w_vec_d   = r_vec_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_elig_valid) begin
                    w_vec_d   = w_elig_idx;
                    w_state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (iack || !(|(w_elig & w_vec_oh))) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_src_q   <= '0;
            r_mask_q  <= MASK_RST[NSRC-1:0];
            r_pend_q  <= '0;
            r_isr_q   <= '0;
            r_trig_q  <= TRIG_RST[NSRC-1:0];
            r_state_q <= ST_IDLE;
            r_vec_q   <= '0;
            r_int_q   <= 1'b0;
        end else begin
            r_src_q   <= src;
            r_mask_q  <= w_mask_d;
            r_pend_q  <= w_pend_d;
            r_isr_q   <= w_isr_d;
            r_trig_q  <= w_trig_d;
            r_state_q <= w_state_d;
            r_vec_q   <= w_vec_d;
            r_int_q   <= (w_state_d == ST_ASSERT);
        end
    end

    assign interrupt = r_int_q;
    assign irq       = r_vec_q;

    always_comb begin
        case (cfg_addr)
            ADDR_MASK:      cfg_rdata = r_mask_q;
            ADDR_PENDING:   cfg_rdata = r_pend_q;
            ADDR_INSERVICE: cfg_rdata = r_isr_q;
            default:        cfg_rdata = r_trig_q;
        endcase
    end

endmodule
`default_nettype wire
